// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter.
//   ZERO_REG_NUM : architectural zero register index; writes to it are dropped.
//   PTR_W        : width of the round-robin pointer (enough for up to 8 requesters).
//   next_ptr     : increment a pointer modulo the requester count.
package wb_port_arbiter_pkg;

    localparam int unsigned ZERO_REG_NUM = 31;
    localparam int unsigned PTR_W        = 3;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p,
                                                  input int unsigned       n);
        if (32'(p) + 32'd1 >= n) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating first-set picker.
//   mask   : requests that may be picked
//   start  : search begins at this bit position and wraps (must be < NUM_REQ)
//   excl   : requests removed from the mask before the search
//   onehot : the first eligible bit at or after start, or all zero
//   found  : at least one eligible bit exists
module wb_rr_pick
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   start,
    input  logic [NUM_REQ-1:0] excl,
    output logic [NUM_REQ-1:0] onehot,
    output logic               found
);

    localparam logic [PTR_W:0]     NUM_P = NUM_REQ[PTR_W:0];
    localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_first;
    logic [PTR_W:0]     back_sh;

    assign eligible = mask & ~excl;
    assign back_sh  = NUM_P - {1'b0, start};

    // Rotate so that 'start' lands on bit 0, isolate the lowest set bit with
    // x & -x, then rotate back. A shift by NUM_REQ yields zero, which makes
    // start == 0 fall out naturally.
    assign rot       = (eligible >> start) | (eligible << back_sh);
    assign rot_first = rot & (~rot + ONE);
    assign onehot    = (rot_first << start) | (rot_first >> back_sh);
    assign found     = |eligible;

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares two register-file write ports among NUM_REQ
// completing functional units with valid/ready backpressure.
//   clock, reset            : clock and synchronous active-low reset
//   req_valid/data/idx      : per-requester result, packed i*W +: W
//   req_ready               : combinational accept, one bit per requester
//   wb_block                : regfile unavailable, nothing is accepted
//   wr_en/idx/data_1 and _2 : registered write ports (1-cycle grant-to-write)
//   any_stalled             : registered, a candidate went ungranted last cycle
// Order of service: urgent requesters (waited MAX_WAIT cycles) in ascending
// index, then the rest round-robin from rr_ptr. Port 2 never writes the same
// index as port 1 in one cycle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_WAIT = 7,
    parameter int DATA_W   = 64,
    parameter int IDX_W    = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*IDX_W-1:0]    req_idx,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wb_block,
    output logic                        wr_en_1,
    output logic [IDX_W-1:0]            wr_idx_1,
    output logic [DATA_W-1:0]           wr_data_1,
    output logic                        wr_en_2,
    output logic [IDX_W-1:0]            wr_idx_2,
    output logic [DATA_W-1:0]           wr_data_2,
    output logic                        any_stalled
);

    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG_NUM);

    logic [IDX_W-1:0]   idx_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] cand, urgent, normal, zero_ready, same_idx, granted;
    logic [NUM_REQ-1:0] u1_oh, r1_oh, u2_oh, r2_oh, g1_oh, g2_oh, last_oh;
    logic               u1_found, r1_found, u2_found, r2_found, g1_found, g2_found;
    logic               active;
    logic [IDX_W-1:0]   g1_idx, g2_idx;
    logic [DATA_W-1:0]  g1_data, g2_data;
    logic [PTR_W-1:0]   last_bin;

    logic [PTR_W-1:0]   rr_ptr_reg;
    logic               wr_en_1_reg, wr_en_2_reg, any_stalled_reg;
    logic [IDX_W-1:0]   wr_idx_1_reg, wr_idx_2_reg;
    logic [DATA_W-1:0]  wr_data_1_reg, wr_data_2_reg;

    // Nothing is accepted while in reset or while the regfile is blocked.
    assign active = reset && !wb_block;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [CNT_W-1:0] cnt_reg;

            assign idx_arr[gi]    = req_idx[gi*IDX_W +: IDX_W];
            assign data_arr[gi]   = req_data[gi*DATA_W +: DATA_W];
            assign cand[gi]       = req_valid[gi] && (idx_arr[gi] != ZERO_IDX);
            assign urgent[gi]     = cand[gi] && (cnt_reg == CNT_MAX);
            assign zero_ready[gi] = active && req_valid[gi] && (idx_arr[gi] == ZERO_IDX);
            // Candidates that would collide with port 1's destination.
            assign same_idx[gi]   = cand[gi] && (idx_arr[gi] == g1_idx);

            // Wait counter keeps counting under wb_block so a long block
            // turns every waiting requester urgent.
            always_ff @(posedge clock) begin
                if (!reset || !cand[gi] || granted[gi]) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign normal = cand & ~urgent;

    wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_urg1 (
        .mask(urgent), .start(PTR_W'(0)), .excl('0), .onehot(u1_oh), .found(u1_found)
    );
    wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_rr1 (
        .mask(normal), .start(rr_ptr_reg), .excl('0), .onehot(r1_oh), .found(r1_found)
    );
    wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_urg2 (
        .mask(urgent), .start(PTR_W'(0)), .excl(same_idx), .onehot(u2_oh), .found(u2_found)
    );
    wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_rr2 (
        .mask(normal), .start(rr_ptr_reg), .excl(same_idx), .onehot(r2_oh), .found(r2_found)
    );

    // Port 1 exclusion via same_idx also removes grant 1 itself.
    assign g1_found = active && (u1_found || r1_found);
    assign g1_oh    = !active ? '0 : (u1_found ? u1_oh : r1_oh);
    assign g2_found = g1_found && (u2_found || r2_found);
    assign g2_oh    = !g1_found ? '0 : (u2_found ? u2_oh : r2_oh);
    assign granted  = g1_oh | g2_oh;
    assign last_oh  = g2_found ? g2_oh : g1_oh;

    assign req_ready = zero_ready | granted;

    always_comb begin
        g1_idx   = '0;
        g1_data  = '0;
        g2_idx   = '0;
        g2_data  = '0;
        last_bin = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (g1_oh[k]) begin
                g1_idx  = idx_arr[k];
                g1_data = data_arr[k];
            end
            if (g2_oh[k]) begin
                g2_idx  = idx_arr[k];
                g2_data = data_arr[k];
            end
            if (last_oh[k]) begin
                last_bin = PTR_W'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_reg      <= '0;
            wr_en_1_reg     <= 1'b0;
            wr_idx_1_reg    <= ZERO_IDX;
            wr_data_1_reg   <= '0;
            wr_en_2_reg     <= 1'b0;
            wr_idx_2_reg    <= ZERO_IDX;
            wr_data_2_reg   <= '0;
            any_stalled_reg <= 1'b0;
        end else begin
            wr_en_1_reg     <= g1_found;
            wr_idx_1_reg    <= g1_found ? g1_idx : ZERO_IDX;
            wr_data_1_reg   <= g1_found ? g1_data : '0;
            wr_en_2_reg     <= g2_found;
            wr_idx_2_reg    <= g2_found ? g2_idx : ZERO_IDX;
            wr_data_2_reg   <= g2_found ? g2_data : '0;
            any_stalled_reg <= |(cand & ~granted);
            if (g1_found) begin
                rr_ptr_reg <= next_ptr(last_bin, NUM_REQ);
            end
        end
    end

    assign wr_en_1     = wr_en_1_reg;
    assign wr_idx_1    = wr_idx_1_reg;
    assign wr_data_1   = wr_data_1_reg;
    assign wr_en_2     = wr_en_2_reg;
    assign wr_idx_2    = wr_idx_2_reg;
    assign wr_data_2   = wr_data_2_reg;
    assign any_stalled = any_stalled_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a priority-list reference model.
module tb_wb_port_arbiter;

    localparam int         N  = 4;
    localparam int         MW = 7;
    localparam int         DW = 64;
    localparam int         IW = 6;
    localparam logic [5:0] ZR = 6'd31;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N*IW-1:0] req_idx;
    logic [N-1:0]    req_ready;
    logic            wb_block;
    logic            wr_en_1, wr_en_2, any_stalled;
    logic [IW-1:0]   wr_idx_1, wr_idx_2;
    logic [DW-1:0]   wr_data_1, wr_data_2;

    wb_port_arbiter #(.NUM_REQ(N), .MAX_WAIT(MW), .DATA_W(DW), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_idx(req_idx), .req_ready(req_ready), .wb_block(wb_block),
        .wr_en_1(wr_en_1), .wr_idx_1(wr_idx_1), .wr_data_1(wr_data_1),
        .wr_en_2(wr_en_2), .wr_idx_2(wr_idx_2), .wr_data_2(wr_data_2),
        .any_stalled(any_stalled)
    );

    always #5 clock = ~clock;

    // Requester-side state.
    logic          v  [N];
    logic [IW-1:0] ix [N];
    logic [DW-1:0] dt [N];
    logic          blk;

    // Reference model state.
    int            m_rr;
    int            m_cnt [N];
    logic [N-1:0]  m_ready;
    int            m_g1, m_g2;
    logic          e_en1, e_en2, e_stall;
    logic [IW-1:0] e_idx1, e_idx2;
    logic [DW-1:0] e_data1, e_data2;

    logic [N-1:0]  last_ready;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*IW-1:0] idx;
        logic            blk;
        logic [N-1:0]    ready;
        logic            en1;
        logic [IW-1:0]   idx1;
        logic            en2;
        logic [IW-1:0]   idx2;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [N*IW-1:0] pk(input logic [5:0] a, input logic [5:0] b,
                                           input logic [5:0] c, input logic [5:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = v[i];
            req_idx[i*IW +: IW]    = ix[i];
            req_data[i*DW +: DW]   = dt[i];
        end
        wb_block = blk;
    endtask

    function automatic bit is_cand(input int i);
        return v[i] && (ix[i] != ZR);
    endfunction

    // Build the service order as an explicit list, then take the first entry
    // and the first later entry with a different destination.
    task automatic model_eval();
        int order[$];
        m_ready = '0;
        m_g1 = -1;
        m_g2 = -1;
        if (reset && !blk) begin
            for (int i = 0; i < N; i++)
                if (v[i] && ix[i] == ZR) m_ready[i] = 1'b1;
            for (int i = 0; i < N; i++)
                if (is_cand(i) && m_cnt[i] == MW) order.push_back(i);
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (is_cand(j) && m_cnt[j] != MW) order.push_back(j);
            end
            if (order.size() > 0) begin
                m_g1 = order[0];
                for (int k = 1; k < order.size(); k++) begin
                    if (ix[order[k]] != ix[m_g1]) begin
                        m_g2 = order[k];
                        break;
                    end
                end
            end
            if (m_g1 >= 0) m_ready[m_g1] = 1'b1;
            if (m_g2 >= 0) m_ready[m_g2] = 1'b1;
        end
    endtask

    task automatic model_update();
        if (!reset) begin
            m_rr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            e_en1 = 0; e_idx1 = ZR; e_data1 = '0;
            e_en2 = 0; e_idx2 = ZR; e_data2 = '0;
            e_stall = 0;
        end else begin
            e_en1   = (m_g1 >= 0);
            e_idx1  = (m_g1 >= 0) ? ix[m_g1] : ZR;
            e_data1 = (m_g1 >= 0) ? dt[m_g1] : '0;
            e_en2   = (m_g2 >= 0);
            e_idx2  = (m_g2 >= 0) ? ix[m_g2] : ZR;
            e_data2 = (m_g2 >= 0) ? dt[m_g2] : '0;
            if (m_g1 >= 0) m_rr = (((m_g2 >= 0) ? m_g2 : m_g1) + 1) % N;
            e_stall = 0;
            for (int i = 0; i < N; i++) begin
                if (is_cand(i) && i != m_g1 && i != m_g2) begin
                    e_stall = 1;
                    m_cnt[i] = (m_cnt[i] + 1 > MW) ? MW : m_cnt[i] + 1;
                end else begin
                    m_cnt[i] = 0;
                end
            end
        end
    endtask

    // One clock of model-checked operation; entered and left just after a posedge.
    task automatic cycle();
        drive();
        #1;
        model_eval();
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(m_ready));
        @(posedge clock);
        model_update();
        #1;
        chk("wr_en_1", 64'(wr_en_1), 64'(e_en1));
        chk("wr_idx_1", 64'(wr_idx_1), 64'(e_idx1));
        chk("wr_data_1", wr_data_1, e_data1);
        chk("wr_en_2", 64'(wr_en_2), 64'(e_en2));
        chk("wr_idx_2", 64'(wr_idx_2), 64'(e_idx2));
        chk("wr_data_2", wr_data_2, e_data2);
        chk("any_stalled", 64'(any_stalled), 64'(e_stall));
        $display("cyc %0d rst=%b blk=%b valid=%b ready=%b wr1=%b:%0d wr2=%b:%0d stall=%b",
                 cyc, reset, blk, req_valid, last_ready, wr_en_1, wr_idx_1,
                 wr_en_2, wr_idx_2, any_stalled);
        cyc++;
    endtask

    task automatic set_reqs(input logic [N-1:0] valid, input logic [N*IW-1:0] idx);
        for (int i = 0; i < N; i++) begin
            v[i]  = valid[i];
            ix[i] = idx[i*IW +: IW];
            dt[i] = 64'hD00D_0000_0000_0000 | 64'(i) | (64'(idx[i*IW +: IW]) << 8);
        end
    endtask

    task automatic refresh_accepted();
        for (int i = 0; i < N; i++)
            if (v[i] && m_ready[i]) dt[i] = dt[i] + 64'h1_0000;
    endtask

    task automatic new_req(input int i);
        int r;
        r = $urandom_range(0, 7);
        ix[i] = (r == 7) ? ZR : 6'(r);
        dt[i] = {$urandom, $urandom};
    endtask

    initial begin
        tbl[0] = '{4'b1111, pk(1, 2, 3, 4),   1'b0, 4'b0011, 1'b1, 6'd1,  1'b1, 6'd2};
        tbl[1] = '{4'b1111, pk(31, 5, 5, 9),  1'b0, 4'b1011, 1'b1, 6'd5,  1'b1, 6'd9};
        tbl[2] = '{4'b0100, pk(0, 0, 7, 0),   1'b0, 4'b0100, 1'b1, 6'd7,  1'b0, 6'd31};
        tbl[3] = '{4'b1111, pk(1, 2, 3, 4),   1'b1, 4'b0000, 1'b0, 6'd31, 1'b0, 6'd31};
        tbl[4] = '{4'b0001, pk(31, 1, 1, 1),  1'b0, 4'b0001, 1'b0, 6'd31, 1'b0, 6'd31};
        tbl[5] = '{4'b1111, pk(8, 8, 8, 8),   1'b0, 4'b0001, 1'b1, 6'd8,  1'b0, 6'd31};
        tbl[6] = '{4'b1010, pk(0, 3, 0, 3),   1'b0, 4'b0010, 1'b1, 6'd3,  1'b0, 6'd31};
        tbl[7] = '{4'b0000, pk(1, 2, 3, 4),   1'b0, 4'b0000, 1'b0, 6'd31, 1'b0, 6'd31};
        tbl[8] = '{4'b1100, pk(0, 0, 4, 6),   1'b0, 4'b1100, 1'b1, 6'd4,  1'b1, 6'd6};

        blk = 1'b0;
        m_rr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        set_reqs(4'b1111, pk(1, 2, 3, 4));
        drive();
        @(posedge clock);
        #1;

        // Reset held two cycles with every requester valid.
        reset = 1'b0;
        cycle();
        cycle();
        chk("reset_wr_idx_1", 64'(wr_idx_1), 64'(31));
        chk("reset_ready", 64'(last_ready), 64'(0));

        // Directed vectors, each from a fresh reset.
        for (int t = 0; t < 9; t++) begin
            reset = 1'b0;
            cycle();
            reset = 1'b1;
            set_reqs(tbl[t].valid, tbl[t].idx);
            blk = tbl[t].blk;
            drive();
            #1;
            chk($sformatf("vec%0d_ready", t), 64'(req_ready), 64'(tbl[t].ready));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_en1", t), 64'(wr_en_1), 64'(tbl[t].en1));
            chk($sformatf("vec%0d_idx1", t), 64'(wr_idx_1), 64'(tbl[t].idx1));
            chk($sformatf("vec%0d_en2", t), 64'(wr_en_2), 64'(tbl[t].en2));
            chk($sformatf("vec%0d_idx2", t), 64'(wr_idx_2), 64'(tbl[t].idx2));
            $display("vec %0d valid=%b ready=%b wr1=%b:%0d wr2=%b:%0d",
                     t, tbl[t].valid, req_ready, wr_en_1, wr_idx_1, wr_en_2, wr_idx_2);
            blk = 1'b0;
        end

        // Round-robin with all four held continuously.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        set_reqs(4'b1111, pk(1, 2, 3, 4));
        cycle();
        chk("rr0_pair", 64'({wr_idx_1, wr_idx_2}), 64'({6'd1, 6'd2}));
        refresh_accepted();
        cycle();
        chk("rr1_pair", 64'({wr_idx_1, wr_idx_2}), 64'({6'd3, 6'd4}));
        refresh_accepted();
        cycle();
        chk("rr2_pair", 64'({wr_idx_1, wr_idx_2}), 64'({6'd1, 6'd2}));

        // Zero-reg plus same-index collision.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        set_reqs(4'b1111, pk(31, 5, 5, 9));
        cycle();
        chk("coll_ready", 64'(last_ready), 64'(4'b1011));
        chk("coll_pair", 64'({wr_idx_1, wr_idx_2}), 64'({6'd5, 6'd9}));
        v[0] = 1'b0; v[1] = 1'b0; v[3] = 1'b0;
        cycle();
        chk("coll_late_ready", 64'(last_ready), 64'(4'b0100));
        chk("coll_late_idx", 64'(wr_idx_1), 64'(5));
        chk("coll_late_en2", 64'(wr_en_2), 64'(0));

        // Long wb_block: every requester saturates and turns urgent.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        set_reqs(4'b1111, pk(1, 2, 3, 4));
        blk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("blk_ready", 64'(last_ready), 64'(0));
            chk("blk_en1", 64'(wr_en_1), 64'(0));
        end
        blk = 1'b0;
        cycle();
        chk("blk_rel_pair", 64'({wr_idx_1, wr_idx_2}), 64'({6'd1, 6'd2}));
        refresh_accepted();
        cycle();
        chk("blk_rel2_pair", 64'({wr_idx_1, wr_idx_2}), 64'({6'd3, 6'd4}));

        // Randomized traffic with block bursts and mid-stream resets.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1;
            new_req(i);
        end
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 63) != 0);
            if (blk) blk = ($urandom_range(0, 7) != 0);
            else     blk = ($urandom_range(0, 15) == 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (v[i] && m_ready[i]) begin
                    v[i] = ($urandom_range(0, 1) == 1);
                    new_req(i);
                end else if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1;
                    new_req(i);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
